// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Single-outstanding request controller in front of a simple synchronous
// memory with a shared tristate data bus.
//
// A request is taken in IDLE. A write spends one cycle strobing mem_wr. A read
// spends one cycle with mem_rd high and captures mem_data on the edge that
// leaves READ. The response is then held in RESP until rsp_ready is seen high
// on a clock edge.
//
// Optional feature (compile-time macro MEM_CTRL_READBACK_EN):
//   Every write is followed by one VERIFY cycle. That cycle reads the location
//   back and flags rsp_err when the data differs from what was written. When
//   the macro is undefined, VERIFY is never entered and rsp_err is tied to 0.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready high only in IDLE)
//   req_wr                1 = write, 0 = read
//   req_addr, req_wdata   request address and write data
//   rsp_valid/rsp_ready   response handshake (rsp_valid high only in RESP)
//   rsp_rdata             read data, or the write echo / readback value
//   rsp_err               readback mismatch flag
//   mem_addr              latched address to the memory
//   mem_data              shared tristate data bus (driven only while mem_wr)
//   mem_wr, mem_rd        memory write strobe / read enable
// -----------------------------------------------------------------------------
module mem_ctrl #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   inout  logic [DATA_WIDTH-1:0] mem_data,
   output logic                  mem_wr,
   output logic                  mem_rd
);

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      VERIFY,
      RESP
   } state_t;

   state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   // The request direction is not stored separately, because the branch
   // taken out of IDLE (WRITE or READ) already encodes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_wr    = 1'b0;
      mem_rd    = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = req_wr ? WRITE : READ;
         end
         WRITE: begin
            mem_wr = 1'b1;
`ifdef MEM_CTRL_READBACK_EN
            state_nxt = VERIFY;
`else
            state_nxt = RESP;
`endif
         end
         READ: begin
            mem_rd    = 1'b1;
            state_nxt = RESP;
         end
         VERIFY: begin
            mem_rd    = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef MEM_CTRL_READBACK_EN
   logic err_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  err_q   <= 1'b0;   // reads always report no error
               end
            end
            READ:    rdata_q <= mem_data;
            VERIFY: begin
               rdata_q <= mem_data;
               err_q   <= (mem_data != wdata_q);
            end
            default: ;
         endcase
      end
   end

   assign rsp_err = err_q;
`else
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
               end
            end
            WRITE:   rdata_q <= wdata_q;   // write echo
            READ:    rdata_q <= mem_data;
            default: ;
         endcase
      end
   end

   assign rsp_err = 1'b0;
`endif

   assign mem_addr  = addr_q;
   assign rsp_rdata = rdata_q;
   assign mem_data  = mem_wr ? wdata_q : 'z;

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;
   localparam int AW = 5;
   localparam int DW = 8;
`ifdef MEM_CTRL_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_wr = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          rsp_ready = 1'b0;
   logic          req_ready, rsp_valid, rsp_err, mem_wr, mem_rd;
   logic [DW-1:0] rsp_rdata;
   logic [AW-1:0] mem_addr;
   wire  [DW-1:0] mem_data;

   logic          force_zero = 1'b0;
   logic [DW-1:0] mem [32];
   logic [DW-1:0] ref_mem [32];

   int total = 0;
   int bad = 0;
   int nresp = 0;

   mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_wr(mem_wr), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int i);
      return DW'(i * 37 + 5);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Memory environment: drives the bus while mem_rd, writes on mem_wr edges.
   assign mem_data = mem_rd ? (force_zero ? '0 : mem[mem_addr]) : 'z;

   always @(posedge clk) begin
      if (rst) for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
      else if (mem_wr) mem[mem_addr] <= mem_data;
   end

   // Transaction-level model: one outstanding request, described by its
   // age in cycles since acceptance and its precomputed response.
   logic          pend = 1'b0;
   int            n = 0;
   logic          p_wr;
   logic [AW-1:0] p_addr;
   logic [DW-1:0] p_wdata, p_rdata;
   logic          p_err;
   int            p_lat;

   always @(negedge clk) begin
      logic exp_valid, exp_wr, exp_rd;
      if (rst) begin
         pend = 1'b0;
         for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);
         chk("rst_req_ready", req_ready, 1);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_rdata", rsp_rdata, 0);
         chk("rst_rsp_err", rsp_err, 0);
         chk("rst_mem_wr", mem_wr, 0);
         chk("rst_mem_rd", mem_rd, 0);
         chk("rst_mem_addr", mem_addr, 0);
      end else begin
         if (pend) n++;
         exp_valid = pend && (n >= p_lat);
         exp_wr    = pend && p_wr && (n == 1);
         exp_rd    = pend && ((!p_wr && n == 1) || (p_wr && RB && n == 2));
         chk("wr_rd_exclusive", mem_wr & mem_rd, 0);
         chk("req_ready", req_ready, !pend);
         chk("rsp_valid", rsp_valid, exp_valid);
         chk("mem_wr", mem_wr, exp_wr);
         chk("mem_rd", mem_rd, exp_rd);
         if (pend) chk("mem_addr", mem_addr, p_addr);
         if (exp_wr) chk("mem_data_wr", mem_data, p_wdata);
         if (exp_rd) chk("mem_data_rd", mem_data, p_rdata);
         if (exp_valid) begin
            chk("rsp_rdata", rsp_rdata, p_rdata);
            chk("rsp_err", rsp_err, p_err);
         end
         if (pend && n > 100) begin
            chk("rsp_timeout", 1, 0);
            pend = 1'b0;
         end else if (exp_valid && rsp_ready) begin
            pend = 1'b0;
            nresp++;
         end else if (!pend && req_valid) begin
            pend    = 1'b1;
            n       = 0;
            p_wr    = req_wr;
            p_addr  = req_addr;
            p_wdata = req_wdata;
            if (req_wr) begin
               p_lat   = RB ? 3 : 2;
               p_rdata = (RB && force_zero) ? '0 : req_wdata;
               p_err   = RB && (p_rdata != req_wdata);
               ref_mem[req_addr] = req_wdata;
            end else begin
               p_lat   = 2;
               p_rdata = ref_mem[req_addr];
               p_err   = 1'b0;
            end
         end
      end
   end

   // Issues one request and returns the response plus its latency (cycles
   // from the accepting edge to the first cycle with rsp_valid high).
   task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int hold, output logic [DW-1:0] rd, output logic e,
                         output int lat);
      int k;
      rd = '0; e = 1'b0; lat = 0;
      @(posedge clk); #2;
      req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; rsp_ready = 1'b0;
      k = 0;
      @(negedge clk);
      while (!req_ready && k < 20) begin @(negedge clk); k++; end
      if (!req_ready) begin
         chk("accept_timeout", 1, 0);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk); #2;
      req_valid = 1'b0; req_wr = $urandom_range(0, 1) == 1;
      req_addr = AW'($urandom); req_wdata = DW'($urandom);
      do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 20);
      if (!rsp_valid) begin
         chk("rsp_wait_timeout", 1, 0);
         return;
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #2;
         req_valid = $urandom_range(0, 1) == 1;   // must be ignored
         req_wr = $urandom_range(0, 1) == 1; req_addr = AW'($urandom);
         @(negedge clk);
      end
      @(posedge clk); #2;
      req_valid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      rd = rsp_rdata; e = rsp_err;
      @(posedge clk); #2;
      rsp_ready = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] rd;
      logic e;
      int lat, nexp, c;
      logic [AW-1:0] wa [3];
      logic [DW-1:0] wd [3];
      nexp = 0;
      wa[0] = 5'h1F; wa[1] = 5'h15; wa[2] = 5'h0A;
      wd[0] = 8'h0F; wd[1] = 8'hAA; wd[2] = 8'h55;

      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Basic write then read back through the controller.
      do_req(1'b1, 5'h00, 8'hF0, 0, rd, e, lat); nexp++;
      chk("w00_latency", lat, RB ? 3 : 2);
      chk("w00_echo", rd, 8'hF0);
      do_req(1'b0, 5'h00, 8'h00, 0, rd, e, lat); nexp++;
      chk("r00_latency", lat, 2);
      chk("r00_data", rd, 8'hF0);
      chk("r00_err", e, 0);

      // Three writes at boundary/alternating patterns, then read them back.
      for (int i = 0; i < 3; i++) begin
         do_req(1'b1, wa[i], wd[i], 0, rd, e, lat); nexp++;
      end
      do_req(1'b0, 5'h1F, 8'h00, 0, rd, e, lat); nexp++;
      chk("r1f_data", rd, 8'h0F);
      do_req(1'b0, 5'h15, 8'h00, 1, rd, e, lat); nexp++;
      chk("r15_data", rd, 8'hAA);
      do_req(1'b0, 5'h0A, 8'h00, 2, rd, e, lat); nexp++;
      chk("r0a_data", rd, 8'h55);

      // Response back-pressure for 5 cycles with stray request pulses.
      do_req(1'b0, 5'h15, 8'h00, 5, rd, e, lat); nexp++;
      chk("stall_data", rd, 8'hAA);
      chk("stall_idle_after", req_ready, 1);

      // Reset in the middle of a read: discarded without a response.
      @(posedge clk); #2;
      req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'h0A;
      @(negedge clk);
      chk("mid_rst_accept_ready", req_ready, 1);
      @(posedge clk); #2;
      req_valid = 1'b0;
      chk("mid_rst_in_read", mem_rd, 1);
      c = nresp;
      rst = 1'b1;
      #1;
      chk("mid_rst_mem_rd", mem_rd, 0);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_req_ready", req_ready, 1);
      @(negedge clk);
      @(posedge clk); #2 rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_rst_no_resp", nresp, c);

      // Randomized traffic checked by the model every cycle.
      for (int t = 0; t < 80; t++) begin
         do_req($urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom),
                $urandom_range(0, 3), rd, e, lat);
         nexp++;
      end

`ifdef MEM_CTRL_READBACK_EN
      // Readback against a memory that returns zero.
      force_zero = 1'b1;
      do_req(1'b1, 5'h07, 8'h3C, 0, rd, e, lat); nexp++;
      chk("rb_latency", lat, 3);
      chk("rb_data", rd, 8'h00);
      chk("rb_err", e, 1);
      force_zero = 1'b0;
`endif

      repeat (3) @(posedge clk);
      chk("response_count", nresp, nexp);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
